// File: rtl/muldiv_hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: function codes,
// FSM state encoding and decode helpers.
package muldiv_hilo_unit_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [5:0] FUNC_MFHI = 6'b010000;
  localparam logic [5:0] FUNC_MTHI = 6'b010001;
  localparam logic [5:0] FUNC_MFLO = 6'b010010;
  localparam logic [5:0] FUNC_MTLO = 6'b010011;
  localparam logic [5:0] FUNC_MULT = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV = 6'b011010;
  localparam logic [5:0] FUNC_DIVU = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  // mult/multu/div/divu share the 0110xx pattern.
  function automatic logic is_muldiv(input logic [5:0] fn);
    return fn[5:2] == 4'b0110;
  endfunction

  // Any instruction that touches HI/LO: the mult/div group or mfhi/mthi/mflo/mtlo (0100xx).
  function automatic logic is_hilo(input logic [5:0] fn);
    return is_muldiv(fn) || (fn[5:2] == 4'b0100);
  endfunction

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// Execute-stage bundle between the pipeline and the HI/LO unit.
interface muldiv_hilo_unit_if
  import muldiv_hilo_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             En;
  logic [5:0]       Function_opcode;
  logic [WIDTH-1:0] Read_data_1;
  logic [WIDTH-1:0] Read_data_2;
  logic             Stall;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HiLo_Result;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output En, Function_opcode, Read_data_1, Read_data_2,
    input  Stall, Busy, Done, HiLo_Result, HI, LO
  );

  modport slave (
    input  En, Function_opcode, Read_data_1, Read_data_2,
    output Stall, Busy, Done, HiLo_Result, HI, LO
  );
endinterface

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide,
// one bit per cycle, over a shared 2*WIDTH accumulator.
module muldiv_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q;
  logic               is_div_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;

  assign last_o = cnt_q == CNT_W'(WIDTH - 1);
  assign acc_o  = acc_q;

  // One multiply or divide step on the accumulator.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    acc_d = acc_q;
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    diff  = '0;
    if (is_div_q) begin
      // Remainder:quotient shifted left; the 33-bit difference's top bit is the borrow.
      diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
      if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else              acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      // Multiplier sits in the low half; the add carry shifts into the top bit.
      if (acc_q[0]) sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
      acc_d = {sum, acc_q[WIDTH-1:1]};
    end
  end

  // Operand load on accept, then one step per CALC cycle.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
    end else if (load_i) begin
      acc_q    <= {{WIDTH{1'b0}}, a_i};
      opb_q    <= b_i;
      is_div_q <= is_div_i;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// HI/LO multiply/divide unit: sequencing FSM, sign handling, HI/LO
// registers and the pipeline stall.
module muldiv_hilo_unit
  import muldiv_hilo_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input logic               clock,
  input logic               reset,
  muldiv_hilo_unit_if.slave bus
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, raw_q;
  logic               done_q, is_div_q, neg_a_q, neg_b_q, div0_q;
  logic [5:0]         fn;
  logic               accept, signed_op, is_div_op, div0, sign_a, sign_b, core_last;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] acc, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign fn        = bus.Function_opcode;
  assign accept    = (state_q == IDLE) && bus.En && is_muldiv(fn);
  assign signed_op = (fn == FUNC_MULT) || (fn == FUNC_DIV);
  assign is_div_op = (fn == FUNC_DIV) || (fn == FUNC_DIVU);
  assign div0      = is_div_op && (bus.Read_data_2 == '0);
  assign sign_a    = signed_op && bus.Read_data_1[WIDTH-1];
  assign sign_b    = signed_op && bus.Read_data_2[WIDTH-1];
  // Magnitude read as unsigned, so 0x80000000 stays 2^31 rather than going negative.
  assign abs_a     = sign_a ? (WIDTH'(0) - bus.Read_data_1) : bus.Read_data_1;
  assign abs_b     = sign_b ? (WIDTH'(0) - bus.Read_data_2) : bus.Read_data_2;

  muldiv_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clock    (clock),
    .reset    (reset),
    .load_i   (accept),
    .step_i   (state_q == CALC),
    .is_div_i (is_div_op),
    .a_i      (abs_a),
    .b_i      (abs_b),
    .last_o   (core_last),
    .acc_o    (acc)
  );

  assign prod_fix = neg_a_q ? ((2 * WIDTH)'(0) - acc) : acc;
  assign quo_fix  = neg_a_q ? (WIDTH'(0) - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
  assign rem_fix  = neg_b_q ? (WIDTH'(0) - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];

  // Next state and HI/LO write selection.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (accept)                                state_d = div0 ? FIX : CALC;
        else if (bus.En && (fn == FUNC_MTHI))      hi_d = bus.Read_data_1;
        else if (bus.En && (fn == FUNC_MTLO))      lo_d = bus.Read_data_1;
      end
      CALC: if (core_last) state_d = FIX;
      FIX: begin
        state_d = IDLE;
        if (div0_q) begin
          hi_d = raw_q;
          lo_d = '1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, HI/LO, Done pulse and per-operation flags captured on accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
      raw_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= (state_q == FIX);
      if (accept) begin
        is_div_q <= is_div_op;
        neg_a_q  <= sign_a ^ sign_b;
        neg_b_q  <= sign_a;
        div0_q   <= div0;
        raw_q    <= bus.Read_data_1;
      end
    end
  end

  assign bus.Busy        = (state_q != IDLE);
  assign bus.Done        = done_q;
  assign bus.HI          = hi_q;
  assign bus.LO          = lo_q;
  assign bus.Stall       = bus.En && is_hilo(fn) && (bus.Busy || accept);
  assign bus.HiLo_Result = (bus.En && (fn == FUNC_MFHI)) ? hi_q :
                           (bus.En && (fn == FUNC_MFLO)) ? lo_q : '0;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit with hand-computed results.
module tb_muldiv_hilo_unit;
  import muldiv_hilo_unit_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  muldiv_hilo_unit_if #(.WIDTH(32)) bus ();

  muldiv_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; return at the falling edge with outputs settled.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Issue a mult/div, hold it while stalled and check result and latency.
  // Latency counts clock edges from the accept edge to the first Done cycle.
  task automatic run_op(input string tag, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_lat);
    int lat;
    bit stall_ok;
    lat      = 0;
    stall_ok = 1'b1;
    bus.En              = 1'b1;
    bus.Function_opcode = fn;
    bus.Read_data_1     = a;
    bus.Read_data_2     = b;
    #1;
    check({tag, "_stall_accept"}, 32'(bus.Stall), 32'd1);
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (bus.Done) begin
        lat = n;
        break;
      end
      if (!bus.Stall || !bus.Busy) stall_ok = 1'b0;
    end
    bus.En = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_stall_held"}, 32'(stall_ok), 32'd1);
    check({tag, "_hi"}, bus.HI, exp_hi);
    check({tag, "_lo"}, bus.LO, exp_lo);
    tick();
    check({tag, "_done_single"}, 32'(bus.Done), 32'd0);
    check({tag, "_busy_after"}, 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    bit done_seen;
    reset               = 1'b1;
    bus.En              = 1'b0;
    bus.Function_opcode = '0;
    bus.Read_data_1     = '0;
    bus.Read_data_2     = '0;
    @(negedge clock);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_hi", bus.HI, 32'h0);
    check("rst_lo", bus.LO, 32'h0);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_stall", 32'(bus.Stall), 32'd0);

    run_op("multu_max", FUNC_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34);
    run_op("mult_neg", FUNC_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 34);
    run_op("mult_minint", FUNC_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 34);
    run_op("div_neg", FUNC_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34);
    run_op("divu", FUNC_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34);
    run_op("divu_zero", FUNC_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 2);

    // Non-HI/LO function code: ignored, no stall, no operation started.
    bus.En              = 1'b1;
    bus.Function_opcode = 6'b100000;
    #1;
    check("other_stall", 32'(bus.Stall), 32'd0);
    tick();
    check("other_busy", 32'(bus.Busy), 32'd0);

    // Moves to and from HI/LO complete without stalling.
    bus.Function_opcode = FUNC_MTHI;
    bus.Read_data_1     = 32'h12345678;
    #1;
    check("mthi_stall", 32'(bus.Stall), 32'd0);
    tick();
    bus.Function_opcode = FUNC_MTLO;
    bus.Read_data_1     = 32'hCAFEF00D;
    #1;
    check("mtlo_stall", 32'(bus.Stall), 32'd0);
    tick();
    check("mthi_hi", bus.HI, 32'h12345678);
    bus.Function_opcode = FUNC_MFHI;
    #1;
    check("mfhi_result", bus.HiLo_Result, 32'h12345678);
    check("mfhi_stall", 32'(bus.Stall), 32'd0);
    tick();
    bus.Function_opcode = FUNC_MFLO;
    #1;
    check("mflo_result", bus.HiLo_Result, 32'hCAFEF00D);
    check("mflo_stall", 32'(bus.Stall), 32'd0);
    tick();

    // Reset while a mult is in CALC with an mflo waiting behind it.
    bus.Function_opcode = FUNC_MULT;
    bus.Read_data_1     = 32'd5;
    bus.Read_data_2     = 32'd3;
    #1;
    tick();
    bus.Function_opcode = FUNC_MFLO;
    for (int k = 0; k < 10; k++) tick();
    check("abort_pre_stall", 32'(bus.Stall), 32'd1);
    check("abort_pre_busy", 32'(bus.Busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("abort_stall", 32'(bus.Stall), 32'd0);
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_hi", bus.HI, 32'h0);
    check("abort_lo", bus.LO, 32'h0);
    done_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.Done) done_seen = 1'b1;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    bus.En = 1'b0;
    tick();

    run_op("multu_after_abort", FUNC_MULTU, 32'd6, 32'd7, 32'h0, 32'd42, 34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
